// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data cache memory-port arbiter.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin tie-break).
package mem_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic {
    REQ_ICACHE = 1'b0,
    REQ_DCACHE = 1'b1
  } req_id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // One-hot requester mask for a requester id.
  function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
    return (id == REQ_DCACHE) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/arb_pick2.sv
// Two-way combinational winner selection for mem_arbiter.
// MEM_ARB_ROUND_ROBIN_EN defined: ties go to the requester not granted last.
// MEM_ARB_ROUND_ROBIN_EN undefined: ties always go to the dcache.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  req_id_t            last_grant,
`endif
  output logic               any_valid,
  output req_id_t            winner
);

  // A lone requester always wins; only a tie consults the tie-break rule.
  always_comb begin
    any_valid = |req_valid;
    winner    = REQ_DCACHE;
    if (req_valid == 2'b01) begin
      winner = REQ_ICACHE;
    end else if (req_valid == 2'b10) begin
      winner = REQ_DCACHE;
    end else if (req_valid == 2'b11) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      winner = (last_grant == REQ_ICACHE) ? REQ_DCACHE : REQ_ICACHE;
`else
      winner = REQ_DCACHE;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one backing-memory port between the icache and dcache refill paths.
// One transaction outstanding at a time: IDLE -> ISSUE -> WAIT -> IDLE.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin tie-break,
// builds a last-grant register); default build uses dcache-wins-ties.
//
// Handshakes: a requester raises req_valid[i] with stable addr/we/wdata and
// holds them until req_ready[i] is seen high; req_ready is combinational and
// only ever high in IDLE, for the winner. The memory request is offered with
// mem_req_valid and held stable until mem_req_ready is high on a clock edge.
// mem_resp_valid completes the transaction only in WAIT (reads and write
// acks alike); resp_valid[owner] pulses for one cycle the cycle after.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*LINE_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [LINE_W-1:0]         resp_rdata,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [ADDR_W-1:0]         mem_req_addr,
  output logic                      mem_req_we,
  output logic [LINE_W-1:0]         mem_req_wdata,
  input  logic                      mem_resp_valid,
  input  logic [LINE_W-1:0]         mem_resp_rdata,
  output arb_state_t                dbg_state
);

  arb_state_t state;
  req_id_t    owner;
  req_id_t    winner;
  logic       any_valid;
  logic       accept;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_id_t    last_grant;
`endif

  arb_pick2 u_pick (
    .req_valid  (req_valid),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_grant (last_grant),
`endif
    .any_valid  (any_valid),
    .winner     (winner)
  );

  // Grant is visible in the same cycle it is taken; held off while in reset.
  assign accept    = reset && (state == IDLE) && any_valid;
  assign req_ready = accept ? id_onehot(winner) : '0;
  assign dbg_state = state;

  // Transaction FSM with registered memory-side and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      owner         <= REQ_ICACHE;
      resp_valid    <= '0;
      resp_rdata    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_we    <= 1'b0;
      mem_req_wdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant    <= REQ_DCACHE;
`endif
    end else begin
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            state         <= ISSUE;
            owner         <= winner;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= (winner == REQ_DCACHE) ? req_addr[2*ADDR_W-1:ADDR_W]
                                                    : req_addr[ADDR_W-1:0];
            mem_req_we    <= (winner == REQ_DCACHE) ? req_we[1] : req_we[0];
            mem_req_wdata <= (winner == REQ_DCACHE) ? req_wdata[2*LINE_W-1:LINE_W]
                                                    : req_wdata[LINE_W-1:0];
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant    <= winner;
`endif
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            resp_rdata <= mem_resp_rdata;
            resp_valid <= id_onehot(owner);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A memory response with nothing outstanding is dropped; flag it.
  a_resp_only_in_wait: assert property (
    @(posedge clk) disable iff (!reset) mem_resp_valid |-> (state == WAIT)
  ) else $warning("mem_arbiter: stray mem_resp_valid outside WAIT dropped");

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level arbitration model and a response scoreboard.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;

  logic                      clk;
  logic                      reset;
  logic [1:0]                req_valid;
  logic [1:0]                req_ready;
  logic [2*ADDR_W-1:0]       req_addr;
  logic [1:0]                req_we;
  logic [2*LINE_W-1:0]       req_wdata;
  logic [1:0]                resp_valid;
  logic [LINE_W-1:0]         resp_rdata;
  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [ADDR_W-1:0]         mem_req_addr;
  logic                      mem_req_we;
  logic [LINE_W-1:0]         mem_req_wdata;
  logic                      mem_resp_valid;
  logic [LINE_W-1:0]         mem_resp_rdata;
  arb_state_t                dbg_state;

  int checks = 0;
  int failures = 0;

  // Pending request per requester, as the requesters see it.
  bit                 p_v[2];
  logic [ADDR_W-1:0]  p_addr[2];
  logic               p_we[2];
  logic [LINE_W-1:0]  p_wd[2];
  int                 model_last;

  // Scoreboard: expected response data and owner, in issue order.
  logic [LINE_W-1:0]  exp_q[$];
  int                 owner_q[$];

  bit                 force_rd;
  logic [LINE_W-1:0]  forced_rd;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_we         (req_we),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_we     (mem_req_we),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .dbg_state      (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_reqs();
    req_valid = {p_v[1], p_v[0]};
    req_addr  = {p_addr[1], p_addr[0]};
    req_we    = {p_we[1], p_we[0]};
    req_wdata = {p_wd[1], p_wd[0]};
  endtask

  task automatic set_req(input int r, input logic [ADDR_W-1:0] a, input logic we,
                         input logic [LINE_W-1:0] wd);
    p_v[r] = 1'b1;
    p_addr[r] = a;
    p_we[r] = we;
    p_wd[r] = wd;
  endtask

  task automatic new_req(input int r);
    set_req(r, $urandom & 32'hFFFF_FFC0, 1'($urandom_range(0, 1)), rand_line());
  endtask

  task automatic do_reset();
    reset = 1'b0;
    p_v[0] = 1'b0;
    p_v[1] = 1'b0;
    drive_reqs();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    model_last = 1;
    exp_q.delete();
    owner_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Reference arbitration: a lone requester wins; a tie goes to the dcache,
  // or with round-robin to whoever was not granted last.
  function automatic int model_pick();
    if (p_v[0] && !p_v[1]) return 0;
    if (p_v[1] && !p_v[0]) return 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return 1 - model_last;
`else
    return 1;
`endif
  endfunction

  // Runs up to n transactions. fill: 0 = directed only, 1 = random new
  // requests, 2 = keep both requesters busy. rdly/sdly: memory ready and
  // response delays (-1 = random). Each next grant is taken in the same
  // cycle as the previous response pulse.
  task automatic run_txns(input int n, input int fill, input int rdly, input int sdly);
    int win, dly, o;
    logic [1:0] exp_ready;
    logic [ADDR_W-1:0] w_addr;
    logic w_we;
    logic [LINE_W-1:0] w_wd, rd, e;
    for (int t = 0; t < n; t++) begin
      for (int r = 0; r < 2; r++) begin
        if (fill == 1 && !p_v[r] && $urandom_range(0, 1) == 1) new_req(r);
        if (fill == 2 && !p_v[r]) new_req(r);
      end
      if (fill != 0 && !p_v[0] && !p_v[1]) new_req(int'($urandom_range(0, 1)));
      if (!p_v[0] && !p_v[1]) break;
      drive_reqs();
      #1;
      win = model_pick();
      exp_ready = (win == 1) ? 2'b10 : 2'b01;
      checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL grant t=%0d: req_ready=%b expected %b", t, req_ready, exp_ready); end
      w_addr = p_addr[win]; w_we = p_we[win]; w_wd = p_wd[win];
      model_last = win;
      p_v[win] = 1'b0;
      tick();
      drive_reqs();
      #1;
      checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL issue_valid t=%0d: got %b expected 1", t, mem_req_valid); end
      checks++; if (mem_req_addr !== w_addr) begin failures++; $display("FAIL issue_addr t=%0d: got %h expected %h", t, mem_req_addr, w_addr); end
      checks++; if (mem_req_we !== w_we) begin failures++; $display("FAIL issue_we t=%0d: got %b expected %b", t, mem_req_we, w_we); end
      checks++; if (mem_req_wdata !== w_wd) begin failures++; $display("FAIL issue_wdata t=%0d: got %h expected %h", t, mem_req_wdata, w_wd); end
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL issue_ready t=%0d: got %b expected 00", t, req_ready); end
      checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL issue_resp t=%0d: got %b expected 00", t, resp_valid); end
      dly = (rdly < 0) ? int'($urandom_range(0, 3)) : rdly;
      repeat (dly) begin
        tick();
        #1;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== w_addr || mem_req_wdata !== w_wd) begin failures++; $display("FAIL stall_hold t=%0d: valid=%b addr=%h expected valid=1 addr=%h", t, mem_req_valid, mem_req_addr, w_addr); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL stall_ready t=%0d: got %b expected 00", t, req_ready); end
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      #1;
      checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL wait_valid t=%0d: got %b expected 0", t, mem_req_valid); end
      checks++; if (dbg_state !== WAIT) begin failures++; $display("FAIL wait_state t=%0d: got %0d expected %0d", t, dbg_state, WAIT); end
      dly = (sdly < 0) ? int'($urandom_range(0, 3)) : sdly;
      repeat (dly) begin
        tick();
        #1;
        checks++; if (resp_valid !== 2'b00 || req_ready !== 2'b00) begin failures++; $display("FAIL wait_quiet t=%0d: resp_valid=%b req_ready=%b expected 00/00", t, resp_valid, req_ready); end
      end
      rd = force_rd ? forced_rd : rand_line();
      mem_resp_valid = 1'b1;
      mem_resp_rdata = rd;
      exp_q.push_back(rd);
      owner_q.push_back(win);
      tick();
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      #1;
      e = exp_q.pop_front();
      o = owner_q.pop_front();
      exp_ready = (o == 1) ? 2'b10 : 2'b01;
      checks++; if (resp_valid !== exp_ready) begin failures++; $display("FAIL resp_valid t=%0d: got %b expected %b", t, resp_valid, exp_ready); end
      if (!w_we) begin
        checks++; if (resp_rdata !== e) begin failures++; $display("FAIL resp_rdata t=%0d: got %h expected %h", t, resp_rdata, e); end
      end
      checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL resp_state t=%0d: got %0d expected %0d", t, dbg_state, IDLE); end
    end
    p_v[0] = 1'b0;
    p_v[1] = 1'b0;
    drive_reqs();
    tick();
    #1;
    checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL resp_pulse_width: got %b expected 00", resp_valid); end
  endtask

  // Scenario tasks
  task automatic test_reset();
    reset = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    checks++; if (resp_valid !== 2'b00 || resp_rdata !== '0) begin failures++; $display("FAIL reset_resp: valid=%b rdata=%h expected 0/0", resp_valid, resp_rdata); end
    checks++; if (mem_req_valid !== 1'b0 || mem_req_we !== 1'b0) begin failures++; $display("FAIL reset_mem_ctl: valid=%b we=%b expected 0/0", mem_req_valid, mem_req_we); end
    checks++; if (mem_req_addr !== '0 || mem_req_wdata !== '0) begin failures++; $display("FAIL reset_mem_data: addr=%h wdata=%h expected 0", mem_req_addr, mem_req_wdata); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
    do_reset();
    tick();
    #1;
    checks++; if (dbg_state !== IDLE || mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_release: state=%0d mem_req_valid=%b expected IDLE/0", dbg_state, mem_req_valid); end
  endtask

  task automatic test_single_read();
    do_reset();
    set_req(0, 32'h0000_0100, 1'b0, '0);
    force_rd = 1'b1;
    forced_rd = {4{32'hA5A5_A5A5}};
    run_txns(1, 0, 0, 2);
    force_rd = 1'b0;
  endtask

  task automatic test_tie();
    do_reset();
    set_req(1, 32'h0000_0200, 1'b1, rand_line());
    set_req(0, 32'h0000_0300, 1'b0, '0);
    run_txns(2, 0, 0, 0);
  endtask

  task automatic test_stall();
    do_reset();
    set_req(0, 32'h0000_0800, 1'b0, '0);
    set_req(1, 32'h0000_0840, 1'b1, rand_line());
    run_txns(2, 0, 5, -1);
  endtask

  task automatic test_spurious_resp();
    do_reset();
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rand_line();
    tick();
    mem_resp_valid = 1'b0;
    #1;
    checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL spurious_resp: got %b expected 00", resp_valid); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL spurious_state: got %0d expected %0d", dbg_state, IDLE); end
    tick();
    #1;
    checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL spurious_late: got %b expected 00", resp_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 32'h0000_0500, 1'b0, '0);
    drive_reqs();
    tick();
    p_v[0] = 1'b0;
    drive_reqs();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #1;
    checks++; if (dbg_state !== WAIT) begin failures++; $display("FAIL midreset_setup: got %0d expected %0d", dbg_state, WAIT); end
    req_valid = 2'b10;
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b00 || resp_valid !== 2'b00 || resp_rdata !== '0) begin failures++; $display("FAIL midreset_resp: ready=%b valid=%b rdata=%h expected 0", req_ready, resp_valid, resp_rdata); end
    checks++; if (mem_req_valid !== 1'b0 || mem_req_we !== 1'b0 || mem_req_addr !== '0 || mem_req_wdata !== '0) begin failures++; $display("FAIL midreset_mem: valid=%b addr=%h expected 0", mem_req_valid, mem_req_addr); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL midreset_state: got %0d expected %0d", dbg_state, IDLE); end
    do_reset();
    repeat (3) begin
      tick();
      #1;
      checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL midreset_noresp: got %b expected 00", resp_valid); end
    end
    run_txns(3, 1, -1, -1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req(1, 32'h0000_0400, 1'b0, '0);
    set_req(0, 32'h0000_0600, 1'b0, '0);
    run_txns(1, 0, 0, 0);
    set_req(1, 32'h0000_0440, 1'b0, '0);
    run_txns(10, 2, -1, -1);
  endtask

  task automatic test_random();
    do_reset();
    run_txns(40, 1, -1, -1);
  endtask

  // Sequence and final report
  initial begin
    reset = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_we = '0;
    req_wdata = '0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    force_rd = 1'b0;
    forced_rd = '0;
    model_last = 1;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_tie();
    test_stall();
    test_spurious_resp();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single backing-memory port between the instruction-cache and data-cache `cache_controller` refill/writeback paths. It accepts one line-sized request at a time from either cache, forwards it to memory, and routes the memory response back to the requester that issued it. It sits in `top` between the two cache controllers' memory-side ports and the external memory interface.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width.
- `LINE_W`, 128, cache-line data width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; `reset`=0 clears all state immediately.
- `req_valid`  in  2  per-requester request valid; bit 0 = icache, bit 1 = dcache.
- `req_ready`  out  2  per-requester request accepted this cycle.
- `req_addr`  in  2*ADDR_W  request addresses, requester i in slice [i*ADDR_W +: ADDR_W].
- `req_we`  in  2  1 = line write, 0 = line read.
- `req_wdata`  in  2*LINE_W  write data per requester.
- `resp_valid`  out  2  one-cycle response pulse to the owning requester.
- `resp_rdata`  out  LINE_W  read data, shared bus; valid only with `resp_valid`.
- `mem_req_valid`  out  1  request to memory.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_req_addr`  out  ADDR_W  latched address.
- `mem_req_we`  out  1  latched write enable.
- `mem_req_wdata`  out  LINE_W  latched write data.
- `mem_resp_valid`  in  1  memory response (read data or write ack).
- `mem_resp_rdata`  in  LINE_W  memory read data.

## Operation
- One outstanding transaction. FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any `req_valid`, pick winner, assert `req_ready[winner]` combinationally in the same cycle, latch addr/we/wdata and owner id; go to ISSUE. `req_ready` is 0 in every other state and for the loser.
- ISSUE: `mem_req_valid`=1, `mem_req_*` driven from latch and held stable until `mem_req_ready`=1; then go to WAIT.
- WAIT: on `mem_resp_valid`, register `mem_resp_rdata` into `resp_rdata`, pulse `resp_valid[owner]` next cycle, go to IDLE.
- Write requests also complete by `mem_resp_valid` (ack); `resp_rdata` content is don't-care for writes.
- `mem_resp_valid` in IDLE or ISSUE: ignored, no response generated; assertion fires in simulation.
- Requesters must hold `req_valid` and fields stable until `req_ready`; the arbiter never drops a pending valid.
- Tie rule (both valid in IDLE): see Configuration.

## Timing
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_rdata`=0, `mem_req_valid`=0, `mem_req_addr`=0, `mem_req_we`=0, `mem_req_wdata`=0, state IDLE, owner=0, last-grant=1.
- Accept at cycle N -> `mem_req_valid`=1 at N+1.
- `mem_req_ready` at cycle M -> WAIT from M+1; earliest `mem_resp_valid` at M+1.
- `mem_resp_valid` at cycle K -> `resp_valid[owner]`=1 at K+1, state IDLE at K+1; a new request is acceptable at K+1 (same cycle as the response pulse).
- Minimum accept-to-response with zero-latency memory: 3 cycles.
- `reset` asserted mid-transaction: state returns to IDLE, outstanding transaction is abandoned, no response is issued; requesters re-issue after reset.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on a tie, grant the requester not granted last; last-grant register updates on every accept; after reset icache wins the first tie.
- Not defined: fixed priority, dcache always wins ties; last-grant register is not built.

## Structure
- `mem_arb_pkg`: `req_id_t` enum (`REQ_ICACHE`=0, `REQ_DCACHE`=1), `arb_state_t` enum (IDLE, ISSUE, WAIT), `NUM_REQ`=2.
- One sub-module, `arb_pick2`: combinational winner selection from `req_valid` and last-grant, honouring `MEM_ARB_ROUND_ROBIN_EN`.

## Test plan
- Single icache read, addr 0x100, memory ready immediately, response 0xA5A5… after 2 cycles -> `resp_valid[0]` pulses once with that data, `resp_valid[1]` stays 0.
- Both valid in the same cycle, dcache write addr 0x200 and icache read addr 0x300 -> with macro: icache first, then dcache; without: dcache first; second grant occurs in the cycle of the first response pulse.
- `mem_req_ready` held low 5 cycles -> `mem_req_valid` and `mem_req_addr`/`mem_req_wdata` stable all 5 cycles; no `req_ready` to the other requester meanwhile.
- Spurious `mem_resp_valid` in IDLE -> no `resp_valid`, state stays IDLE, assertion reported.
- `reset` driven low during WAIT, then released -> all outputs 0 immediately; no response after release; next request proceeds normally.
- Back-to-back dcache requests to 0x400/0x440 with 10 continuous tie cycles under macro -> grants strictly alternate icache/dcache.
